// File: rtl/team_06_esp_frame_packer_if.sv
// Sample-in / byte-out bus of the ESP frame packer.
// The master side feeds samples and issues byte_take strobes; the slave side is the packer.
interface team_06_esp_frame_packer_if #(
    parameter int DEPTH = 8
);
    logic [15:0]             sample_in;
    logic                    sample_valid;
    logic                    sample_ready;
    logic                    byte_take;
    logic [7:0]              byte_out;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow;

    modport master (
        output sample_in,
        output sample_valid,
        output byte_take,
        input  sample_ready,
        input  byte_out,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        input  byte_take,
        output sample_ready,
        output byte_out,
        output fifo_count,
        output overflow
    );
endinterface

// File: rtl/team_06_esp_frame_packer.sv
// ESP frame packer: buffers 16-bit samples in a small FIFO and presents them
// to the serializer as sync/MSB/LSB byte frames, one byte per byte_take.
module team_06_esp_frame_packer #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic clk,
    input  logic rst,
    team_06_esp_frame_packer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // States are named for the byte currently on byte_out.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_MSB,
        S_LSB
    } state_t;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   hold;
    state_t        state;
    state_t        state_next;
    logic [7:0]    byte_reg;
    logic [7:0]    byte_next;
    logic          overflow_reg;
    logic          ready;
    logic          push;
    logic          pop;

    // Ready comes from the registered count only, so no input reaches it combinationally.
    assign ready = (count != FULL);
    assign push  = bus.sample_valid && ready;

    assign bus.sample_ready = ready;
    assign bus.byte_out     = byte_reg;
    assign bus.fifo_count   = count;
    assign bus.overflow     = overflow_reg;

    // Sample storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.sample_in;
        end
    end

    // Pointers wrap naturally; count moves only on a lone push or a lone pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Frame sample is captured on pop and held until the next frame starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (pop) begin
            hold <= mem[rd_ptr];
        end
    end

    // State, presented byte and the registered overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            byte_reg     <= IDLE_BYTE;
            overflow_reg <= 1'b0;
        end else begin
            state        <= state_next;
            byte_reg     <= byte_next;
            overflow_reg <= bus.sample_valid && !ready;
        end
    end

    // Advance one byte per take; pop decisions see only the registered count.
    always_comb begin
        state_next = state;
        byte_next  = byte_reg;
        pop        = 1'b0;
        if (bus.byte_take) begin
            case (state)
                S_IDLE, S_LSB: begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = S_SYNC;
                        byte_next  = SYNC_BYTE;
                    end else begin
                        state_next = S_IDLE;
                        byte_next  = IDLE_BYTE;
                    end
                end
                S_SYNC: begin
                    state_next = S_MSB;
                    byte_next  = hold[15:8];
                end
                S_MSB: begin
                    state_next = S_LSB;
                    byte_next  = hold[7:0];
                end
                default: begin
                    state_next = S_IDLE;
                    byte_next  = IDLE_BYTE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_team_06_esp_frame_packer.sv
// Directed bench for the ESP frame packer: reset, framing, overflow and mid-frame reset.
module tb_team_06_esp_frame_packer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    team_06_esp_frame_packer_if #(.DEPTH(8)) bus ();

    team_06_esp_frame_packer #(
        .DEPTH(8),
        .SYNC_BYTE(8'hA5),
        .IDLE_BYTE(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take(input logic valid, input logic [15:0] smp);
        bus.byte_take    = 1'b1;
        bus.sample_valid = valid;
        bus.sample_in    = smp;
        tick();
        bus.byte_take    = 1'b0;
        bus.sample_valid = 1'b0;
    endtask

    task automatic push(input logic [15:0] smp);
        bus.sample_valid = 1'b1;
        bus.sample_in    = smp;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.byte_take    = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_overflow got=%b exp=0", bus.overflow);
        end
        for (int i = 0; i < 3; i++) begin
            take(1'b0, 16'h0);
            n_cmp++;
            if (bus.byte_out !== 8'h00) begin
                n_bad++;
                $display("FAIL idle_byte[%0d] got=%h exp=00", i, bus.byte_out);
            end
            n_cmp++;
            if (bus.fifo_count !== 4'd0 || bus.sample_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL idle_state[%0d] count=%0d ready=%b exp count=0 ready=1", i, bus.fifo_count, bus.sample_ready);
            end
            tick();
        end
        $display("reset/idle: byte_out=%h count=%0d", bus.byte_out, bus.fifo_count);
    endtask

    task automatic test_single_frame();
        logic [7:0] exp_b [4];
        exp_b = '{8'hA5, 8'h12, 8'h34, 8'h00};
        push(16'h1234);
        n_cmp++;
        if (bus.fifo_count !== 4'd1 || bus.byte_out !== 8'h00) begin
            n_bad++;
            $display("FAIL single_push count=%0d byte=%h exp count=1 byte=00", bus.fifo_count, bus.byte_out);
        end
        for (int i = 0; i < 4; i++) begin
            take(1'b0, 16'h0);
            n_cmp++;
            if (bus.byte_out !== exp_b[i]) begin
                n_bad++;
                $display("FAIL single_byte[%0d] got=%h exp=%h", i, bus.byte_out, exp_b[i]);
            end
            if (i == 0) begin
                n_cmp++;
                if (bus.fifo_count !== 4'd0) begin
                    n_bad++;
                    $display("FAIL single_pop_count got=%0d exp=0", bus.fifo_count);
                end
            end
            $display("single frame take %0d: byte_out=%h", i, bus.byte_out);
            repeat (23) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [7];
        exp_b = '{8'hA5, 8'hBE, 8'hEF, 8'hA5, 8'h01, 8'h02, 8'h00};
        push(16'hBEEF);
        push(16'h0102);
        n_cmp++;
        if (bus.fifo_count !== 4'd2) begin
            n_bad++;
            $display("FAIL b2b_count got=%0d exp=2", bus.fifo_count);
        end
        for (int i = 0; i < 7; i++) begin
            take(1'b0, 16'h0);
            n_cmp++;
            if (bus.byte_out !== exp_b[i]) begin
                n_bad++;
                $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, bus.byte_out, exp_b[i]);
            end
            $display("back-to-back take %0d: byte_out=%h", i, bus.byte_out);
            repeat (2) tick();
        end
    endtask

    task automatic test_overflow_and_full_pop();
        logic [15:0] exp_s [8];
        for (int i = 0; i < 8; i++) begin
            push(16'h1100 + 16'(i));
        end
        n_cmp++;
        if (bus.sample_ready !== 1'b0 || bus.fifo_count !== 4'd8) begin
            n_bad++;
            $display("FAIL full_after_8 ready=%b count=%0d exp ready=0 count=8", bus.sample_ready, bus.fifo_count);
        end
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL no_early_overflow got=%b exp=0", bus.overflow);
        end
        push(16'hDEAD);
        n_cmp++;
        if (bus.overflow !== 1'b1 || bus.fifo_count !== 4'd8) begin
            n_bad++;
            $display("FAIL overflow_pulse ovf=%b count=%0d exp ovf=1 count=8", bus.overflow, bus.fifo_count);
        end
        tick();
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow_once got=%b exp=0", bus.overflow);
        end
        $display("overflow: dropped 9th sample, count=%0d", bus.fifo_count);

        // Pop 0x1100, refill to full, walk to the LSB byte.
        take(1'b0, 16'h0);
        push(16'h2200);
        take(1'b0, 16'h0);
        take(1'b0, 16'h0);
        n_cmp++;
        if (bus.byte_out !== 8'h00 || bus.fifo_count !== 4'd8) begin
            n_bad++;
            $display("FAIL full_in_lsb byte=%h count=%0d exp byte=00 count=8", bus.byte_out, bus.fifo_count);
        end

        // Full, in LSB, take with a sample offered: pop wins, sample dropped.
        take(1'b1, 16'h3333);
        n_cmp++;
        if (bus.fifo_count !== 4'd7 || bus.overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL full_pop count=%0d ovf=%b exp count=7 ovf=1", bus.fifo_count, bus.overflow);
        end
        n_cmp++;
        if (bus.byte_out !== 8'hA5 || bus.sample_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL full_pop_next byte=%h ready=%b exp byte=a5 ready=1", bus.byte_out, bus.sample_ready);
        end
        $display("full+pop: count=%0d byte_out=%h", bus.fifo_count, bus.byte_out);

        // Drain: 0x1101 is in flight, then 0x1102..0x1107, 0x2200; neither dropped sample appears.
        exp_s = '{16'h1101, 16'h1102, 16'h1103, 16'h1104, 16'h1105, 16'h1106, 16'h1107, 16'h2200};
        for (int f = 0; f < 8; f++) begin
            if (f != 0) begin
                take(1'b0, 16'h0);
                n_cmp++;
                if (bus.byte_out !== 8'hA5) begin
                    n_bad++;
                    $display("FAIL drain_sync[%0d] got=%h exp=a5", f, bus.byte_out);
                end
            end
            take(1'b0, 16'h0);
            n_cmp++;
            if (bus.byte_out !== exp_s[f][15:8]) begin
                n_bad++;
                $display("FAIL drain_msb[%0d] got=%h exp=%h", f, bus.byte_out, exp_s[f][15:8]);
            end
            take(1'b0, 16'h0);
            n_cmp++;
            if (bus.byte_out !== exp_s[f][7:0]) begin
                n_bad++;
                $display("FAIL drain_lsb[%0d] got=%h exp=%h", f, bus.byte_out, exp_s[f][7:0]);
            end
            $display("drain frame %0d: sample=%h", f, exp_s[f]);
        end
        take(1'b0, 16'h0);
        n_cmp++;
        if (bus.byte_out !== 8'h00 || bus.fifo_count !== 4'd0) begin
            n_bad++;
            $display("FAIL drain_end byte=%h count=%0d exp byte=00 count=0", bus.byte_out, bus.fifo_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_b [4];
        exp_b = '{8'hA5, 8'h55, 8'h66, 8'h00};
        for (int i = 0; i < 4; i++) begin
            push(16'hAA01 + 16'(i));
        end
        take(1'b0, 16'h0);
        take(1'b0, 16'h0);
        n_cmp++;
        if (bus.byte_out !== 8'hAA || bus.fifo_count !== 4'd3) begin
            n_bad++;
            $display("FAIL pre_reset byte=%h count=%0d exp byte=aa count=3", bus.byte_out, bus.fifo_count);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.byte_out !== 8'h00 || bus.fifo_count !== 4'd0) begin
            n_bad++;
            $display("FAIL async_reset byte=%h count=%0d exp byte=00 count=0", bus.byte_out, bus.fifo_count);
        end
        tick();
        rst = 1'b0;
        tick();
        push(16'h5566);
        for (int i = 0; i < 4; i++) begin
            take(1'b0, 16'h0);
            n_cmp++;
            if (bus.byte_out !== exp_b[i]) begin
                n_bad++;
                $display("FAIL restart_byte[%0d] got=%h exp=%h", i, bus.byte_out, exp_b[i]);
            end
            $display("after reset take %0d: byte_out=%h", i, bus.byte_out);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow_and_full_pop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
